// File: rtl/cdie_clk_req_ctrl.sv
// cdie_clk_req_ctrl
//   Per-channel clock request/acknowledge handshake controller. Each channel
//   raises clk_req on consumer demand (ch_want). It reports ch_ready once the
//   synchronised ack arrives. It releases the request when demand goes away
//   and waits for the ack to drop before returning to idle. A missing ack edge
//   within TIMEOUT cycles sets a sticky per-channel error flag. The error flag
//   never blocks the channel.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no request, clock not granted
//   REQ   | clk_req high, waiting for the synchronised ack to rise
//   ON    | clock granted, clk_req and ch_ready high
//   REL   | clk_req low, waiting for the synchronised ack to fall
//
// Ports
//   local_half_bridge_clk         block clock, rising edge
//   local_half_bridge_rst_b_async async active-low reset
//   ch_want[NUM_CH]               consumer request per channel (synchronous)
//   clk_ack[NUM_CH]               clock source ack per channel (asynchronous)
//   err_clr[NUM_CH]               single-cycle clear of ch_err
//   clk_req[NUM_CH]               registered request to the clock source
//   ch_ready[NUM_CH]              registered clock-granted indication
//   ch_err[NUM_CH]                sticky timeout / ack-loss flag
//   all_ready                     registered AND of ch_ready
//   local_half_bridge_rst_b_sync  reset, async assert / sync deassert

module cdie_clk_req_ctrl #(
    parameter int NUM_CH      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 200,
    parameter int TIMEOUT_W   = 8
) (
    input  logic              local_half_bridge_clk,
    input  logic              local_half_bridge_rst_b_async,
    input  logic [NUM_CH-1:0] ch_want,
    input  logic [NUM_CH-1:0] clk_ack,
    input  logic [NUM_CH-1:0] err_clr,
    output logic [NUM_CH-1:0] clk_req,
    output logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] ch_err,
    output logic              all_ready,
    output logic              local_half_bridge_rst_b_sync
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ON   = 2'd2,
        ST_REL  = 2'd3
    } state_e;

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] TO_SAT  = TIMEOUT_W'(TIMEOUT);

    // Reset synchroniser: ones shift in after release, output is the last stage.
    logic [SYNC_STAGES-1:0] rst_sync_q;

    always_ff @(posedge local_half_bridge_clk or negedge local_half_bridge_rst_b_async) begin
        if (!local_half_bridge_rst_b_async) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign local_half_bridge_rst_b_sync = rst_sync_q[SYNC_STAGES-1];

    // Ack synchronisers, one chain per channel bit.
    logic [NUM_CH-1:0] ack_sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] ack_s;

    always_ff @(posedge local_half_bridge_clk or negedge local_half_bridge_rst_b_async) begin
        if (!local_half_bridge_rst_b_async) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ack_sync_q[i] <= '0;
            end
        end else begin
            ack_sync_q[0] <= clk_ack;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ack_sync_q[i] <= ack_sync_q[i-1];
            end
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e                state_q;
        state_e                state_d;
        logic [TIMEOUT_W-1:0]  cnt_q;
        logic [TIMEOUT_W-1:0]  cnt_d;
        logic                  req_q;
        logic                  rdy_q;
        logic                  err_q;
        logic                  err_set;
        logic                  timeout;

        assign timeout = (cnt_q == TO_LAST);

        always_comb begin
            state_d = state_q;
            err_set = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ch_want[g]) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A late ack still wins over withdrawal or timeout.
                    if (ack_s[g]) begin
                        state_d = ST_ON;
                    end else if (!ch_want[g] || timeout) begin
                        state_d = ST_REL;
                        err_set = timeout;
                    end
                end
                ST_ON: begin
                    // Ack lost while the clock is in use is an error.
                    if (!ack_s[g]) begin
                        state_d = ST_REL;
                        err_set = 1'b1;
                    end else if (!ch_want[g]) begin
                        state_d = ST_REL;
                    end
                end
                ST_REL: begin
                    if (!ack_s[g]) begin
                        state_d = ST_IDLE;
                    end else if (timeout) begin
                        err_set = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Counter restarts on any state change and saturates so the
        // timeout compare can fire only once per REQ/REL visit.
        always_comb begin
            cnt_d = cnt_q;
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if ((state_q == ST_REQ || state_q == ST_REL) && cnt_q != TO_SAT) begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
            end
        end

        always_ff @(posedge local_half_bridge_clk or negedge local_half_bridge_rst_b_async) begin
            if (!local_half_bridge_rst_b_async) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                req_q   <= 1'b0;
                rdy_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                req_q   <= (state_d == ST_REQ) || (state_d == ST_ON);
                rdy_q   <= (state_d == ST_ON);
                err_q   <= err_set | (err_q & ~err_clr[g]);
            end
        end

        assign clk_req[g]  = req_q;
        assign ch_ready[g] = rdy_q;
        assign ch_err[g]   = err_q;
    end

    logic all_ready_q;

    always_ff @(posedge local_half_bridge_clk or negedge local_half_bridge_rst_b_async) begin
        if (!local_half_bridge_rst_b_async) begin
            all_ready_q <= 1'b0;
        end else begin
            all_ready_q <= &ch_ready;
        end
    end

    assign all_ready = all_ready_q;

endmodule

// File: tb/tb_cdie_clk_req_ctrl.sv
// Directed bench for cdie_clk_req_ctrl: default instance (3 ch, 2-stage sync,
// timeout 200) and a small instance (8 ch, 3-stage sync, timeout 4).

module tb_cdie_clk_req_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_b;
    logic [2:0] a_want, a_ack, a_clr, a_req, a_rdy, a_err;
    logic       a_all, a_rs;

    logic       b_rst_b;
    logic [7:0] b_want, b_ack, b_clr, b_req, b_rdy, b_err;
    logic       b_all, b_rs;

    cdie_clk_req_ctrl u_dut_a (
        .local_half_bridge_clk        (clk),
        .local_half_bridge_rst_b_async(a_rst_b),
        .ch_want                      (a_want),
        .clk_ack                      (a_ack),
        .err_clr                      (a_clr),
        .clk_req                      (a_req),
        .ch_ready                     (a_rdy),
        .ch_err                       (a_err),
        .all_ready                    (a_all),
        .local_half_bridge_rst_b_sync (a_rs)
    );

    cdie_clk_req_ctrl #(
        .NUM_CH     (8),
        .SYNC_STAGES(3),
        .TIMEOUT    (4),
        .TIMEOUT_W  (8)
    ) u_dut_b (
        .local_half_bridge_clk        (clk),
        .local_half_bridge_rst_b_async(b_rst_b),
        .ch_want                      (b_want),
        .clk_ack                      (b_ack),
        .err_clr                      (b_clr),
        .clk_req                      (b_req),
        .ch_ready                     (b_rdy),
        .ch_err                       (b_err),
        .all_ready                    (b_all),
        .local_half_bridge_rst_b_sync (b_rs)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_b = 1'b0; a_want = '0; a_ack = '0; a_clr = '0;
        b_rst_b = 1'b0; b_want = '0; b_ack = '0; b_clr = '0;

        // Reset state, then release between edges.
        #12;
        chk("rst_req",   a_req, 3'b000);
        chk("rst_rdy",   a_rdy, 3'b000);
        chk("rst_err",   a_err, 3'b000);
        chk("rst_all",   a_all, 1'b0);
        chk("rst_sync",  a_rs,  1'b0);
        a_rst_b = 1'b1;
        b_rst_b = 1'b1;
        tick;
        chk("rsync_e1",  a_rs, 1'b0);
        tick;
        chk("rsync_e2",  a_rs, 1'b1);
        chk("b_rsync_e2", b_rs, 1'b0);
        tick;
        chk("b_rsync_e3", b_rs, 1'b1);

        // Channel 0 handshake with ack raised 5 cycles after the request.
        a_want = 3'b001;
        tick;
        chk("c0_req_e0", a_req, 3'b001);
        chk("c0_rdy_e0", a_rdy, 3'b000);
        repeat (5) tick;
        a_ack = 3'b001;
        tick;
        tick;
        chk("c0_rdy_e7", a_rdy, 3'b000);
        tick;
        chk("c0_rdy_e8", a_rdy, 3'b001);
        chk("c0_req_e8", a_req, 3'b001);

        // Channel 1 timeout with ack held low.
        a_want = 3'b011;
        tick;
        chk("c1_req_e0", a_req, 3'b011);
        repeat (199) tick;
        chk("c1_err_199", a_err, 3'b000);
        chk("c1_req_199", a_req, 3'b011);
        tick;
        chk("c1_err_200", a_err, 3'b010);
        chk("c1_req_200", a_req, 3'b001);
        a_want = 3'b001;
        tick;
        tick;
        chk("c1_err_sticky", a_err, 3'b010);
        chk("c1_req_idle",   a_req, 3'b001);
        a_clr = 3'b010;
        tick;
        a_clr = 3'b000;
        chk("c1_err_clr", a_err, 3'b000);

        // All three channels granted, then channel 2 released.
        a_want = 3'b111;
        a_ack  = 3'b111;
        tick;
        tick;
        tick;
        chk("all_rdy_f2", a_rdy, 3'b111);
        chk("all_f2",     a_all, 1'b0);
        tick;
        chk("all_f3",     a_all, 1'b1);
        a_want = 3'b011;
        tick;
        chk("c2_rdy_g0",  a_rdy, 3'b011);
        chk("c2_req_g0",  a_req, 3'b011);
        chk("all_g0",     a_all, 1'b1);
        tick;
        chk("all_g1",     a_all, 1'b0);

        // Re-request during REL while ack is still high.
        a_want = 3'b111;
        tick;
        tick;
        chk("rel_hold_g3", a_req, 3'b011);
        a_ack = 3'b011;
        tick;
        tick;
        chk("rel_hold_g5", a_req, 3'b011);
        tick;
        chk("rel_idle_g6", a_req, 3'b011);
        tick;
        chk("rereq_g7",    a_req, 3'b111);
        chk("c2_err_none", a_err, 3'b000);

        // Async reset pulse between edges while channels 0/1 are ON.
        #2;
        a_rst_b = 1'b0;
        #1;
        chk("arst_req",  a_req, 3'b000);
        chk("arst_rdy",  a_rdy, 3'b000);
        chk("arst_sync", a_rs,  1'b0);
        a_rst_b = 1'b1;
        tick;
        chk("post_rs_e1",  a_rs,  1'b0);
        chk("post_req_e1", a_req, 3'b111);
        tick;
        chk("post_rs_e2",  a_rs,  1'b1);
        chk("post_rdy_e2", a_rdy, 3'b000);
        tick;
        chk("post_rdy_e3", a_rdy, 3'b011);
        chk("post_err",    a_err, 3'b000);

        // Small instance: 4-cycle grant latency on channel 3.
        b_want = 8'h08;
        b_ack  = 8'h08;
        tick;
        chk("b_req_h0", b_req, 8'h08);
        chk("b_rdy_h0", b_rdy, 8'h00);
        tick;
        tick;
        chk("b_rdy_h2", b_rdy, 8'h00);
        tick;
        chk("b_rdy_h3", b_rdy, 8'h08);

        // Channel 5 timeout after 4 cycles in REQ.
        b_want = 8'h28;
        tick;
        chk("b_req_j0", b_req, 8'h28);
        repeat (3) tick;
        chk("b_err_j3", b_err, 8'h00);
        chk("b_req_j3", b_req, 8'h28);
        tick;
        chk("b_err_j4", b_err, 8'h20);
        chk("b_req_j4", b_req, 8'h08);

        // Channel 6 timeout coinciding with err_clr: set wins; ch5 clears.
        b_want = 8'h48;
        repeat (4) tick;
        b_clr = 8'h60;
        tick;
        b_clr = 8'h00;
        chk("b_set_wins", b_err, 8'h40);
        chk("b_req_k4",   b_req, 8'h08);
        tick;
        tick;
        chk("b_rereq_err", b_req, 8'h48);
        b_want = 8'h08;
        tick;
        tick;
        b_clr = 8'h40;
        tick;
        b_clr = 8'h00;
        chk("b_err_clr",  b_err, 8'h00);
        chk("b_rdy_indep", b_rdy, 8'h08);
        chk("b_all",      b_all, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdie_clk_req_ctrl.md
CDIE_CLK_REQ_CTRL -- requirements
Module: cdie_clk_req_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3, number of independent clock request/ack channels (ch0=bclk, ch1=xtal, ch2=cro); legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2, flop depth of the ack and reset synchronisers; legal range 2..4.
REQ-003 Parameter TIMEOUT, default 200, cycles allowed for an ack edge before a channel error; legal range 2..2^TIMEOUT_W-1.
REQ-004 Parameter TIMEOUT_W, default 8, per-channel timeout counter width.
REQ-005 Port local_half_bridge_clk, input, 1, the single block clock; all state updates on its rising edge.
REQ-006 Port local_half_bridge_rst_b_async, input, 1, asynchronous active-low reset; assertion takes effect immediately, independent of the clock.
REQ-007 Port ch_want, input, NUM_CH, per-channel consumer request for a running clock; synchronous to local_half_bridge_clk.
REQ-008 Port clk_ack, input, NUM_CH, per-channel ack from the clock source; asynchronous.
REQ-009 Port err_clr, input, NUM_CH, per-channel single-cycle clear of ch_err.
REQ-010 Port clk_req, output, NUM_CH, per-channel registered request to the clock source.
REQ-011 Port ch_ready, output, NUM_CH, per-channel registered indication that the clock is granted.
REQ-012 Port ch_err, output, NUM_CH, per-channel sticky timeout flag.
REQ-013 Port all_ready, output, 1, registered AND of ch_ready across all channels.
REQ-014 Port local_half_bridge_rst_b_sync, output, 1, reset asserted asynchronously, deasserted synchronously.

Function
REQ-015 Each clk_ack bit SHALL pass through its own SYNC_STAGES-flop synchroniser (ack_s) before any use.
REQ-016 Each channel SHALL run an independent FSM: IDLE, REQ, ON, REL.
REQ-017 IDLE: clk_req=0, ch_ready=0; ch_want=1 -> REQ.
REQ-018 REQ: clk_req=1; ack_s=1 -> ON; ch_want=0 -> REL; timeout -> REL with ch_err set; ack_s takes priority over ch_want=0 and timeout in the same cycle.
REQ-019 ON: clk_req=1, ch_ready=1; ch_want=0 -> REL; ack_s falling while in ON -> REL with ch_err set.
REQ-020 REL: clk_req=0; ack_s=0 -> IDLE; ch_want is ignored until IDLE is reached; timeout sets ch_err, state remains REL until ack_s=0.
REQ-021 clk_req and ch_ready SHALL be registered decodes of next state, i.e. valid on the edge that enters the state.
REQ-022 Latency: ch_want high at edge t -> clk_req high after edge t; clk_ack rising before edge u -> ch_ready high after edge u+SYNC_STAGES.
REQ-023 The timeout counter SHALL clear on every state entry, increment once per cycle in REQ and REL, and saturate at TIMEOUT; timeout fires on the cycle the count equals TIMEOUT-1 while the awaited ack edge is absent.
REQ-024 ch_err SHALL be sticky until err_clr; set and err_clr in the same cycle -> set wins.
REQ-025 ch_err SHALL NOT block the FSM; a channel in error still re-requests from IDLE.
REQ-026 all_ready SHALL update one cycle after the last ch_ready bit changes.
REQ-027 local_half_bridge_rst_b_sync SHALL go low immediately on reset assertion and high on the SYNC_STAGES-th rising edge after reset release.

Reset
REQ-028 On local_half_bridge_rst_b_async low: all FSMs IDLE, all counters 0, all ack synchronisers 0, clk_req=0, ch_ready=0, ch_err=0, all_ready=0, local_half_bridge_rst_b_sync=0.
REQ-029 Reset asserted mid-handshake SHALL drop clk_req asynchronously, with no REL wait; after release each channel starts in IDLE.

Verification
REQ-030 Defaults: ch_want[0]=1 at edge 0, clk_ack[0] raised 5 cycles later -> clk_req[0]=1 after edge 0, ch_ready[0]=1 at edge 5+2+1; channels 1 and 2 stay IDLE.
REQ-031 clk_ack[1] held 0 with ch_want[1]=1 -> ch_err[1]=1 and clk_req[1]=0 after 200 cycles in REQ; err_clr[1] pulse with no new timeout -> ch_err[1]=0 next cycle.
REQ-032 All 3 channels granted, then ch_want[2]=0 -> all_ready=0 one cycle after ch_ready[2] falls; clk_ack[2] dropped -> channel 2 returns to IDLE.
REQ-033 ch_want re-raised during REL with ack still high -> clk_req stays 0 until ack_s=0, then IDLE, then REQ on the next edge.
REQ-034 Async reset pulsed between clock edges while in ON -> outputs zero immediately; local_half_bridge_rst_b_sync high exactly 2 edges after release.
REQ-035 NUM_CH=8, SYNC_STAGES=3, TIMEOUT=4: per-channel independence, 4-cycle latency, timeout at 4 cycles, and simultaneous set/err_clr (set wins).
